// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, two combinational read ports,
// optional hardwired zero register, optional write-to-read bypass, per-register busy bits.
module reg_file_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic [DATA_W-1:0]        rd_data_a,
  output logic [DATA_W-1:0]        rd_data_b,
  output logic                     rd_busy_a,
  output logic                     rd_busy_b,
  input  logic                     wr_en_0,
  input  logic [ADDR_W-1:0]        wr_addr_0,
  input  logic [DATA_W-1:0]        wr_data_0,
  input  logic                     wr_en_1,
  input  logic [ADDR_W-1:0]        wr_addr_1,
  input  logic [DATA_W-1:0]        wr_data_1,
  input  logic                     set_busy_en,
  input  logic [ADDR_W-1:0]        set_busy_addr,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  // Write-port hits on each read address, used for bypass and busy masking
  logic hit0_a, hit1_a, hit0_b, hit1_b;

  // Next array and scoreboard state; port 1 applied last so it wins collisions
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_en_0) begin
      mem_d[wr_addr_0]  = wr_data_0;
      busy_d[wr_addr_0] = 1'b0;
    end
    if (wr_en_1) begin
      mem_d[wr_addr_1]  = wr_data_1;
      busy_d[wr_addr_1] = 1'b0;
    end
    // A new producer issued in the same cycle the old one retires keeps the bit set
    if (set_busy_en) begin
      busy_d[set_busy_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    hit0_a = (BYPASS != 0) && wr_en_0 && (wr_addr_0 == rd_addr_a);
    hit1_a = (BYPASS != 0) && wr_en_1 && (wr_addr_1 == rd_addr_a);
    hit0_b = (BYPASS != 0) && wr_en_0 && (wr_addr_0 == rd_addr_b);
    hit1_b = (BYPASS != 0) && wr_en_1 && (wr_addr_1 == rd_addr_b);
  end

  always_comb begin
    rd_data_a = mem_q[rd_addr_a];
    if (hit1_a) begin
      rd_data_a = wr_data_1;
    end else if (hit0_a) begin
      rd_data_a = wr_data_0;
    end
    if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
      rd_data_a = '0;
    end
    rd_busy_a = busy_q[rd_addr_a] && !(hit0_a || hit1_a);
  end

  always_comb begin
    rd_data_b = mem_q[rd_addr_b];
    if (hit1_b) begin
      rd_data_b = wr_data_1;
    end else if (hit0_b) begin
      rd_data_b = wr_data_0;
    end
    if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
      rd_data_b = '0;
    end
    rd_busy_b = busy_q[rd_addr_b] && !(hit0_b || hit1_b);
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a default instance (zero reg + bypass) and a plain instance
// (no zero reg, no bypass) share stimulus and are checked against an array model.
module tb_reg_file_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          wr_en_0, wr_en_1, set_busy_en;
  logic [AW-1:0] wr_addr_0, wr_addr_1, set_busy_addr;
  logic [DW-1:0] wr_data_0, wr_data_1;

  logic [DW-1:0]    rd_data_a_z, rd_data_b_z, rd_data_a_n, rd_data_b_n;
  logic             rd_busy_a_z, rd_busy_b_z, rd_busy_a_n, rd_busy_b_n;
  logic [DEPTH-1:0] busy_vec_z, busy_vec_n;

  always #5 clk = ~clk;

  reg_file_mp dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_z), .rd_data_b(rd_data_b_z),
    .rd_busy_a(rd_busy_a_z), .rd_busy_b(rd_busy_b_z),
    .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .set_busy_en(set_busy_en), .set_busy_addr(set_busy_addr),
    .busy_vec(busy_vec_z)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_n), .rd_data_b(rd_data_b_n),
    .rd_busy_a(rd_busy_a_n), .rd_busy_b(rd_busy_b_n),
    .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .set_busy_en(set_busy_en), .set_busy_addr(set_busy_addr),
    .busy_vec(busy_vec_n)
  );

  // Reference state: index by config, z = zero reg + bypass, n = neither
  logic [DW-1:0]    m_z [DEPTH];
  logic [DW-1:0]    m_n [DEPTH];
  logic [DEPTH-1:0] b_z, b_n;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit zcfg);
    if (zcfg) begin
      if (a == 0) return '0;
      if (wr_en_1 && wr_addr_1 == a) return wr_data_1;
      if (wr_en_0 && wr_addr_0 == a) return wr_data_0;
      return m_z[a];
    end
    return m_n[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit zcfg);
    if (zcfg) begin
      if ((wr_en_0 && wr_addr_0 == a) || (wr_en_1 && wr_addr_1 == a)) return 1'b0;
      return b_z[a];
    end
    return b_n[a];
  endfunction

  task automatic update_model();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_z[i] = '0;
        m_n[i] = '0;
      end
      b_z = '0;
      b_n = '0;
    end else begin
      if (wr_en_0) begin
        if (wr_addr_0 != 0) m_z[wr_addr_0] = wr_data_0;
        m_n[wr_addr_0] = wr_data_0;
        b_z[wr_addr_0] = 1'b0;
        b_n[wr_addr_0] = 1'b0;
      end
      if (wr_en_1) begin
        if (wr_addr_1 != 0) m_z[wr_addr_1] = wr_data_1;
        m_n[wr_addr_1] = wr_data_1;
        b_z[wr_addr_1] = 1'b0;
        b_n[wr_addr_1] = 1'b0;
      end
      if (set_busy_en) begin
        if (set_busy_addr != 0) b_z[set_busy_addr] = 1'b1;
        b_n[set_busy_addr] = 1'b1;
      end
    end
  endtask

  // Settle mid-cycle and check every combinational output against the model
  task automatic mid();
    #4;
    check("rd_data_a_z", 64'(rd_data_a_z), 64'(exp_rd(rd_addr_a, 1'b1)));
    check("rd_data_b_z", 64'(rd_data_b_z), 64'(exp_rd(rd_addr_b, 1'b1)));
    check("rd_busy_a_z", 64'(rd_busy_a_z), 64'(exp_busy(rd_addr_a, 1'b1)));
    check("rd_busy_b_z", 64'(rd_busy_b_z), 64'(exp_busy(rd_addr_b, 1'b1)));
    check("rd_data_a_n", 64'(rd_data_a_n), 64'(exp_rd(rd_addr_a, 1'b0)));
    check("rd_data_b_n", 64'(rd_data_b_n), 64'(exp_rd(rd_addr_b, 1'b0)));
    check("rd_busy_a_n", 64'(rd_busy_a_n), 64'(exp_busy(rd_addr_a, 1'b0)));
    check("rd_busy_b_n", 64'(rd_busy_b_n), 64'(exp_busy(rd_addr_b, 1'b0)));
  endtask

  task automatic edge_step();
    @(posedge clk);
    update_model();
    #1;
    check("busy_vec_z", 64'(busy_vec_z), 64'(b_z));
    check("busy_vec_n", 64'(busy_vec_n), 64'(b_n));
  endtask

  task automatic idle();
    rst = 1'b0; wr_en_0 = 1'b0; wr_en_1 = 1'b0; set_busy_en = 1'b0;
    wr_addr_0 = '0; wr_addr_1 = '0; set_busy_addr = '0;
    wr_data_0 = '0; wr_data_1 = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
    return AW'($urandom);
  endfunction

  initial begin
    idle();
    rd_addr_a = '0; rd_addr_b = '0;
    rst = 1'b1;
    @(posedge clk);
    update_model();
    #1;
    mid(); edge_step();

    // Reset state, then a single write via port 0
    idle(); rd_addr_a = 5'd20; rd_addr_b = 5'd31;
    mid();
    check("t1_rd20", 64'(rd_data_a_z), 64'h0);
    check("t1_bv", 64'(busy_vec_z), 64'h0);
    edge_step();
    wr_en_0 = 1'b1; wr_addr_0 = 5'd20; wr_data_0 = 32'h48;
    mid(); edge_step();
    idle();
    mid();
    check("t1_rd48", 64'(rd_data_a_z), 64'h48);
    edge_step();

    // Dual-write collision, then two distinct addresses
    wr_en_0 = 1'b1; wr_addr_0 = 5'd7; wr_data_0 = 32'hAAAA;
    wr_en_1 = 1'b1; wr_addr_1 = 5'd7; wr_data_1 = 32'h5555;
    mid(); edge_step();
    idle(); rd_addr_a = 5'd7;
    mid();
    check("t2_coll_z", 64'(rd_data_a_z), 64'h5555);
    check("t2_coll_n", 64'(rd_data_a_n), 64'h5555);
    edge_step();
    wr_en_0 = 1'b1; wr_addr_0 = 5'd3; wr_data_0 = 32'h3333;
    wr_en_1 = 1'b1; wr_addr_1 = 5'd4; wr_data_1 = 32'h4444;
    mid(); edge_step();
    idle(); rd_addr_a = 5'd3; rd_addr_b = 5'd4;
    mid();
    check("t2_reg3", 64'(rd_data_a_z), 64'h3333);
    check("t2_reg4", 64'(rd_data_b_z), 64'h4444);
    edge_step();

    // Bypass versus no bypass
    wr_en_0 = 1'b1; wr_addr_0 = 5'd9; wr_data_0 = 32'h78; rd_addr_b = 5'd9;
    mid();
    check("t3_byp", 64'(rd_data_b_z), 64'h78);
    check("t3_nobyp_old", 64'(rd_data_b_n), 64'h0);
    edge_step();
    idle();
    mid();
    check("t3_nobyp_new", 64'(rd_data_b_n), 64'h78);
    edge_step();

    // Zero register ignores writes and busy sets
    wr_en_0 = 1'b1; wr_addr_0 = '0; wr_data_0 = 32'hFFFF_FFFF;
    wr_en_1 = 1'b1; wr_addr_1 = '0; wr_data_1 = 32'hFFFF_FFFF;
    set_busy_en = 1'b1; set_busy_addr = '0; rd_addr_a = '0;
    mid();
    check("t4_zero_now", 64'(rd_data_a_z), 64'h0);
    edge_step();
    check("t4_busy0", 64'(busy_vec_z[0]), 64'h0);
    idle();
    mid();
    check("t4_zero_next", 64'(rd_data_a_z), 64'h0);
    edge_step();

    // Scoreboard set, bypass-masked clear, set beats clear
    set_busy_en = 1'b1; set_busy_addr = 5'd12; rd_addr_a = 5'd12;
    mid(); edge_step();
    idle();
    mid();
    check("t5_busy_rd", 64'(rd_busy_a_z), 64'h1);
    check("t5_busy_vec", 64'(busy_vec_z[12]), 64'h1);
    edge_step();
    wr_en_0 = 1'b1; wr_addr_0 = 5'd12; wr_data_0 = 32'hC0DE;
    mid();
    check("t5_mask", 64'(rd_busy_a_z), 64'h0);
    check("t5_nomask", 64'(rd_busy_a_n), 64'h1);
    edge_step();
    check("t5_clr", 64'(busy_vec_z[12]), 64'h0);
    set_busy_en = 1'b1; set_busy_addr = 5'd12;
    mid(); edge_step();
    check("t5_set_wins", 64'(busy_vec_z[12]), 64'h1);

    // Reset overrides same-cycle write and set
    idle();
    set_busy_en = 1'b1; set_busy_addr = 5'd5;
    wr_en_0 = 1'b1; wr_addr_0 = 5'd5; wr_data_0 = 32'h1234; rst = 1'b1;
    mid(); edge_step();
    idle(); rd_addr_a = 5'd5;
    check("t6_bv", 64'(busy_vec_z), 64'h0);
    mid();
    check("t6_rd5", 64'(rd_data_a_z), 64'h0);
    edge_step();

    // Randomized traffic with address bias toward collisions
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 99) == 0);
      wr_en_0       = 1'($urandom);
      wr_en_1       = 1'($urandom);
      set_busy_en   = 1'($urandom);
      wr_addr_0     = rand_addr();
      wr_addr_1     = rand_addr();
      set_busy_addr = rand_addr();
      rd_addr_a     = rand_addr();
      rd_addr_b     = rand_addr();
      wr_data_0     = $urandom;
      wr_data_1     = $urandom;
      mid();
      edge_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file. It is the successor to the current 32x32, 1-write/2-read CPU register file.
- Two write ports, so two instructions can retire per cycle.
- Optional hardwired zero register.
- Optional write-to-read bypass.
- Per-register busy (scoreboard) bits that the issue logic sets and write-back clears.

Sits between decode/issue (reads, busy set) and write-back (writes).

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to read ports and masks busy

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
rd_addr_a  input  ADDR_W  read port A address
rd_addr_b  input  ADDR_W  read port B address
rd_data_a  output  DATA_W  read port A data (combinational)
rd_data_b  output  DATA_W  read port B data (combinational)
rd_busy_a  output  1  busy bit of rd_addr_a (combinational)
rd_busy_b  output  1  busy bit of rd_addr_b (combinational)
wr_en_0  input  1  write port 0 enable
wr_addr_0  input  ADDR_W  write port 0 address
wr_data_0  input  DATA_W  write port 0 data
wr_en_1  input  1  write port 1 enable (higher priority)
wr_addr_1  input  ADDR_W  write port 1 address
wr_data_1  input  DATA_W  write port 1 data
set_busy_en  input  1  mark set_busy_addr busy
set_busy_addr  input  ADDR_W  register to mark busy
busy_vec  output  2**ADDR_W  registered busy bits, bit i = register i

Behaviour:
Reset and register state
- One clock (clk); reset rst is synchronous and active-high.
- rst=1 at a rising edge: all registers <= 0, all busy bits <= 0.
- rst overrides all writes and set_busy in that cycle; reset mid-burst simply discards in-flight writes.
- After reset: rd_data_* = 0, rd_busy_* = 0, busy_vec = 0.

Writes
- Take effect at the rising edge where wr_en_x=1; the value is readable from the array the following cycle.
- Both ports enabled to the same address: port 1 value stored, port 0 dropped.
- ZERO_REG=1: writes to address 0 ignored on both ports.

Reads (combinational, zero latency)
- Base value: rd_data_x = array[rd_addr_x].
- BYPASS=1 and an enabled write in the current cycle targets rd_addr_x: rd_data_x = that write's data. Port 1 wins over port 0.
- BYPASS=0: array value only; new data visible one cycle after the write edge.
- ZERO_REG=1 and rd_addr_x=0: rd_data_x = 0 regardless of bypass.
- Ports A and B are fully independent; same address on both gives identical outputs.

Busy bits (next-state per register i, evaluated at each edge, rst=0)
- Set if set_busy_en && set_busy_addr==i.
- Else cleared if (wr_en_0 && wr_addr_0==i) || (wr_en_1 && wr_addr_1==i).
- Else hold.
- Set beats clear on the same address in the same cycle (new producer issued as old one retires).
- ZERO_REG=1: bit 0 is constant 0; set requests to register 0 are ignored.
- rd_busy_x = busy[rd_addr_x], except BYPASS=1 and an enabled write hits rd_addr_x this cycle gives 0 (data is being forwarded).
- busy_vec is the registered state, unmasked by bypass.

Other
- Address width: no out-of-range case, since depth = 2**ADDR_W exactly.
- No X propagation: unused write data ignored when wr_en=0.

Test Plan:
1. Reset, then write: rst=1 for 2 cycles, then read addr 20/31 -> rd_data=0, busy_vec=0. Write 0x48 to reg 20 via port 0, read next cycle -> rd_data_a=0x48.
2. Dual-write collision: wr_en_0=1 addr 7 data 0xAAAA, wr_en_1=1 addr 7 data 0x5555 same cycle -> next cycle reg 7 = 0x5555. Different addresses 3/4 -> both stored.
3. Bypass: BYPASS=1, write 0x78 to reg 9 while rd_addr_b=9 -> rd_data_b=0x78 same cycle. Repeat with BYPASS=0 -> old value this cycle, 0x78 next cycle.
4. Zero register: write 0xFFFFFFFF to addr 0 on both ports and set_busy addr 0 -> rd_data_a(0)=0 same and next cycle, busy_vec[0]=0.
5. Scoreboard: set_busy reg 12 -> next cycle rd_busy_a=1, busy_vec[12]=1. Write reg 12 -> rd_busy_a=0 same cycle (bypass), busy_vec[12]=0 next cycle. Simultaneous set+write reg 12 -> busy_vec[12]=1.
6. Reset mid-operation: set_busy reg 5, write 0x1234 to reg 5, assert rst in same cycle -> next cycle reg 5 = 0, busy_vec=0.
